// File: rtl/slc3_mem_pkg.sv
// Shared types for the SLC3 memory responder: FSM state encoding and the default MMIO word address.
package slc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} mem_state_t;
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
endpackage

// File: rtl/slc3_ram_array.sv
// Single-port word RAM: synchronous write, combinational read at the same address. Contents survive reset.
module slc3_ram_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for the SLC3 MAR/MDR bus: 4-phase req/ready handshake with
// programmable wait states, word RAM backing and one MMIO word (switches in, hex display out).
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_RD,
  input  logic        Mem_WR,
  input  logic [15:0] Mem_Addr,
  input  logic [15:0] Mem_WData,
  input  logic [9:0]  SW,
  output logic [15:0] Mem_RData,
  output logic        Mem_R,
  output logic        Mem_Busy,
  output logic [15:0] HEX_Data
);
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q, wdata_q;
  logic             wr_q;
  logic             req, access;
  logic [15:0]      eff_addr, eff_wdata;
  logic             op_wr, is_io, ram_we;
  logic [15:0]      ram_rdata;

  assign req = Mem_RD | Mem_WR;

  // With zero wait states the access lands on the accept edge, before anything is latched.
  assign eff_addr  = (state_q == IDLE) ? Mem_Addr  : addr_q;
  assign eff_wdata = (state_q == IDLE) ? Mem_WData : wdata_q;
  assign op_wr     = (state_q == IDLE) ? Mem_WR    : wr_q;
  assign is_io     = (eff_addr == IO_ADDR);
  assign ram_we    = access & op_wr & ~is_io;
  assign Mem_Busy  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    Mem_R   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (WAIT_STATES == 0) ? DONE : WAIT;
          access  = (WAIT_STATES == 0);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          access  = 1'b1;
        end
      end
      DONE: begin
        Mem_R   = 1'b1;
        state_d = req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset landing on the DONE-entry edge must abort the pending access.
    if (Reset) access = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (state_q == IDLE) begin
      addr_q  <= Mem_Addr;
      wdata_q <= Mem_WData;
      wr_q    <= Mem_WR;
    end
  end

  // Access stage: register updates on the edge that enters DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Mem_RData <= '0;
      HEX_Data  <= '0;
    end else if (access) begin
      if (op_wr) begin
        if (is_io) HEX_Data <= eff_wdata;
      end else begin
        Mem_RData <= is_io ? {6'b0, SW} : ram_rdata;
      end
    end
  end

  slc3_ram_array #(.ADDR_W(ADDR_W), .DATA_W(16)) u_ram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (eff_addr[ADDR_W-1:0]),
    .wdata (eff_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: directed table, reset-abort sequence, zero-wait instance, random traffic vs model.
module tb_slc3_mem_responder;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [9:0]  sw;
  logic [15:0] rdata, hex;
  logic        mem_r, busy;

  logic        rd1, wr1;
  logic [15:0] addr1, wdata1;
  logic [15:0] rdata1, hex1;
  logic        r1, busy1;

  always #5 clk = ~clk;

  slc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(WS), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(rst), .Mem_RD(mem_rd), .Mem_WR(mem_wr), .Mem_Addr(mem_addr),
    .Mem_WData(mem_wdata), .SW(sw), .Mem_RData(rdata), .Mem_R(mem_r), .Mem_Busy(busy),
    .HEX_Data(hex));

  slc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(clk), .Reset(rst), .Mem_RD(rd1), .Mem_WR(wr1), .Mem_Addr(addr1),
    .Mem_WData(wdata1), .SW(sw), .Mem_RData(rdata1), .Mem_R(r1), .Mem_Busy(busy1),
    .HEX_Data(hex1));

  int checks = 0;
  int errors = 0;

  // Reference model: word store indexed by the low address bits, plus the two output registers.
  logic [15:0] m_mem [1024];
  bit          m_known [1024];
  logic [15:0] m_rdata;
  bit          m_rd_known;
  logic [15:0] m_hex;
  logic [15:0] last_rd, last_hex;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [9:0]  sw;
    int          hold;
    bit          chk;
    logic [15:0] exp_rdata;
    logic [15:0] exp_hex;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = 16'h0;
    m_rd_known = 1'b1;
    m_hex = 16'h0;
  endtask

  task automatic txn(input logic rd_i, input logic wr_i, input logic [15:0] a,
                     input logic [15:0] d, input logic [9:0] s, input int hold);
    int  n;
    bit  seen;
    bit  io;
    io = (a == 16'hFFFF);
    if (wr_i) begin
      if (io) m_hex = d;
      else begin
        m_mem[a[9:0]] = d;
        m_known[a[9:0]] = 1'b1;
      end
    end else begin
      m_rdata = io ? {6'b0, s} : m_mem[a[9:0]];
      m_rd_known = io || m_known[a[9:0]];
    end
    @(negedge clk);
    mem_rd = rd_i; mem_wr = wr_i; mem_addr = a; mem_wdata = d; sw = s;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_accept", busy, 1'b1);
    mem_addr = 16'($urandom);
    mem_wdata = 16'($urandom);
    n = 1;
    seen = 0;
    while (!seen && n <= 10) begin
      if (mem_r) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    chk("ready_latency", n, WS + 1);
    last_rd = rdata;
    last_hex = hex;
    if (m_rd_known) chk("model_rdata", rdata, m_rdata);
    chk("model_hex", hex, m_hex);
    if (hold == 0) begin
      mem_rd = 0; mem_wr = 0;
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_no_ready", mem_r, 1'b0);
        chk("hold_busy", busy, 1'b1);
      end
      mem_rd = 0; mem_wr = 0;
    end
    @(negedge clk);
    chk("idle_ready_low", mem_r, 1'b0);
    chk("idle_busy_low", busy, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    model_reset();
    //         rd    wr    addr      wdata     sw       hold chk exp_rdata exp_hex
    tbl[0]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 10'h000, 0, 0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 10'h000, 0, 0, 16'h0000, 16'h0000};
    tbl[2]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 10'h000, 1, 1, 16'hBEEF, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'h03FF, 16'h0F0F, 10'h000, 0, 1, 16'hBEEF, 16'h0000};
    tbl[4]  = '{1'b0, 1'b1, 16'hFFFF, 16'h1234, 10'h000, 2, 1, 16'hBEEF, 16'h1234};
    tbl[5]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 10'h000, 0, 1, 16'h0F0F, 16'h1234};
    tbl[6]  = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 10'h2A5, 0, 1, 16'h02A5, 16'h1234};
    tbl[7]  = '{1'b1, 1'b0, 16'h03FF, 16'h0000, 10'h000, 6, 1, 16'h0F0F, 16'h1234};
    tbl[8]  = '{1'b0, 1'b1, 16'h0400, 16'h00AA, 10'h000, 0, 1, 16'h0F0F, 16'h1234};
    tbl[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 10'h000, 0, 1, 16'h00AA, 16'h1234};
    tbl[10] = '{1'b1, 1'b1, 16'h0030, 16'hCAFE, 10'h000, 0, 1, 16'h00AA, 16'h1234};
    tbl[11] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 10'h000, 0, 1, 16'hCAFE, 16'h1234};
    tbl[12] = '{1'b0, 1'b1, 16'h0020, 16'h1111, 10'h000, 0, 1, 16'hCAFE, 16'h1234};
    tbl[13] = '{1'b1, 1'b0, 16'h8020, 16'h0000, 10'h000, 0, 1, 16'h1111, 16'h1234};

    rst = 1; mem_rd = 0; mem_wr = 0; mem_addr = 0; mem_wdata = 0; sw = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_ready", mem_r, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata", rdata, 16'h0);
    chk("rst_hex", hex, 16'h0);
    chk("rst_busy_ws0", busy1, 1'b0);

    for (int i = 0; i < 14; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].sw, tbl[i].hold);
      if (tbl[i].chk) begin
        chk("tbl_rdata", last_rd, tbl[i].exp_rdata);
        chk("tbl_hex", last_hex, tbl[i].exp_hex);
      end
    end

    // Reset on the edge that would have completed a write to 0x0020.
    @(negedge clk);
    mem_wr = 1; mem_addr = 16'h0020; mem_wdata = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ready_w0", mem_r, 1'b0);
    @(negedge clk);
    chk("abort_ready_w1", mem_r, 1'b0);
    rst = 1; mem_wr = 0;
    @(negedge clk);
    rst = 0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", mem_r, 1'b0);
    chk("abort_rdata", rdata, 16'h0);
    chk("abort_hex", hex, 16'h0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ready", mem_r, 1'b0);
    end
    txn(1'b1, 1'b0, 16'h0020, 16'h0, 10'h0, 0);
    chk("abort_ram_kept", last_rd, 16'h1111);

    // Zero-wait instance: ready in the cycle right after acceptance.
    @(negedge clk);
    wr1 = 1; addr1 = 16'h0005; wdata1 = 16'h0042;
    @(negedge clk);
    chk("ws0_wr_ready", r1, 1'b1);
    wr1 = 0;
    @(negedge clk);
    chk("ws0_wr_release", r1, 1'b0);
    rd1 = 1; addr1 = 16'h0005;
    @(negedge clk);
    chk("ws0_rd_ready", r1, 1'b1);
    chk("ws0_rdata", rdata1, 16'h0042);
    rd1 = 0;
    @(negedge clk);
    chk("ws0_rd_release", r1, 1'b0);
    chk("ws0_busy", busy1, 1'b0);

    for (int i = 0; i < 16; i++)
      txn(1'b0, 1'b1, {6'($urandom), 10'(i)}, 16'($urandom), 10'h0, 0);
    for (int k = 0; k < 40; k++) begin
      int op;
      logic [15:0] a;
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : {6'($urandom), 10'($urandom_range(0, 15))};
      txn(op != 1, op != 0, a, 16'($urandom), 10'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
